// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and FSM encoding for the instruction fetch unit
package ifu_pkg;
    localparam int INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_KILL} state_e;
endpackage

// File: rtl/ifu_dff_rst_en_clr.sv
// DFF_RST_EN_CLR: register with sync reset, clear-to-zero and load enable (rst > clr > en)
module DFF_RST_EN_CLR #(
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        q <= rst ? RST_VAL : clr ? '0 : en ? d : q;
endmodule

// File: rtl/ifu.sv
// ifu: PC generation, single-outstanding imem fetch and IF/ID register with one-deep hold buffer
module ifu import ifu_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_sys,
    input  logic                   rst_sys,
    output logic                   o_imem_req_vld,
    input  logic                   i_imem_req_rdy,
    output logic [31:0]            o_imem_addr,
    input  logic                   i_imem_rsp_vld,
    input  logic [INSTR_WIDTH-1:0] i_imem_rsp_instr,
    input  logic                   i_redirect,
    input  logic [31:0]            i_redirect_pc,
    input  logic                   i_if2id_stall,
    input  logic                   i_if2id_flush,
    output logic [31:0]            o_pc_d,
    output logic [INSTR_WIDTH-1:0] o_instr_d,
    output logic                   o_instr_vld
);
    state_e state, state_nxt;
    logic [31:0] pc;
    logic [INSTR_WIDTH-1:0] hold_instr, load_instr;
    logic [INSTR_WIDTH:0] ifid_q;
    logic hs, take, load;

    assign hs = o_imem_req_vld & i_imem_req_rdy;
    // an instruction may enter IF/ID only when neither stalled nor flushed; otherwise it parks in HOLD
    assign take = !i_if2id_stall & !i_if2id_flush;
    assign load = !i_redirect & take & ((state == S_WAIT & i_imem_rsp_vld) | state == S_HOLD);
    assign load_instr = state == S_HOLD ? hold_instr : i_imem_rsp_instr;

    always_ff @(posedge clk_sys)
        state <= rst_sys ? S_REQ : state_nxt;

    always_ff @(posedge clk_sys) begin
        if (rst_sys)
            pc <= RESET_PC;
        else if (i_redirect)
            pc <= i_redirect_pc & ~32'd3;
        else if (load)
            pc <= pc + 32'd4;
        if (state == S_WAIT & i_imem_rsp_vld & !i_redirect & !take)
            hold_instr <= i_imem_rsp_instr;
    end

    always_comb begin
        state_nxt = S_REQ;
        case (state)
            S_REQ:   state_nxt = hs ? (i_redirect ? S_KILL : S_WAIT) : S_REQ;
            S_WAIT:  state_nxt = i_imem_rsp_vld ? (i_redirect || take ? S_REQ : S_HOLD)
                                                : (i_redirect ? S_KILL : S_WAIT);
            S_HOLD:  state_nxt = i_redirect || take ? S_REQ : S_HOLD;
            S_KILL:  state_nxt = i_imem_rsp_vld ? S_REQ : S_KILL;
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        o_imem_req_vld = state == S_REQ & !rst_sys;
        o_imem_addr = pc;
    end

    DFF_RST_EN_CLR #(.W(INSTR_WIDTH + 1)) u_ifid_instr (
        .clk(clk_sys),
        .rst(rst_sys),
        .en(load),
        .clr(i_redirect | i_if2id_flush),
        .d({1'b1, load_instr}),
        .q(ifid_q)
    );

    DFF_RST_EN_CLR #(.W(32)) u_ifid_pc (
        .clk(clk_sys),
        .rst(rst_sys),
        .en(load),
        .clr(1'b0),
        .d(pc),
        .q(o_pc_d)
    );

    // a cleared register holds zero; the bubble encoding is substituted on the way out
    assign o_instr_vld = ifid_q[INSTR_WIDTH];
    assign o_instr_d = o_instr_vld ? ifid_q[INSTR_WIDTH-1:0] : NOP_INSTR;
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed stimulus with a memory model; a monitor checks request addresses and IF/ID loads against queues
module tb_ifu;
    logic        clk_sys = 0;
    logic        rst_sys;
    logic        o_imem_req_vld;
    logic        i_imem_req_rdy;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_vld;
    logic [31:0] i_imem_rsp_instr;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_if2id_stall;
    logic        i_if2id_flush;
    logic [31:0] o_pc_d;
    logic [31:0] o_instr_d;
    logic        o_instr_vld;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int n_cmp = 0;
    int n_fail = 0;
    int lat = 0;
    logic [31:0] exp_addr[$];
    logic [63:0] exp_load[$];

    ifu dut (
        .clk_sys(clk_sys),
        .rst_sys(rst_sys),
        .o_imem_req_vld(o_imem_req_vld),
        .i_imem_req_rdy(i_imem_req_rdy),
        .o_imem_addr(o_imem_addr),
        .i_imem_rsp_vld(i_imem_rsp_vld),
        .i_imem_rsp_instr(i_imem_rsp_instr),
        .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .i_if2id_stall(i_if2id_stall),
        .i_if2id_flush(i_if2id_flush),
        .o_pc_d(o_pc_d),
        .o_instr_d(o_instr_d),
        .o_instr_vld(o_instr_vld)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h0 ? 32'h0000_0093 : a == 32'h14 ? 32'hDEAD_BEEF : {~a[15:0], a[15:0]};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic ld);
        exp_addr.push_back(a);
        if (ld) exp_load.push_back({a, mem(a)});
    endtask

    task automatic wait_req(input logic [31:0] a);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            if (o_imem_req_vld && o_imem_addr == a) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_req: no request to %h within 40 cycles", a);
    endtask

    task automatic step;
        @(posedge clk_sys);
        #1;
    endtask

    // memory: responds lat cycles after the cycle following an accepted request
    initial begin
        int cnt;
        logic hs;
        logic [31:0] a, pa;
        cnt = -1;
        pa = 0;
        i_imem_rsp_vld = 0;
        i_imem_rsp_instr = 0;
        forever begin
            @(negedge clk_sys);
            hs = o_imem_req_vld && i_imem_req_rdy;
            a = o_imem_addr;
            @(posedge clk_sys);
            #1;
            i_imem_rsp_vld = 0;
            if (rst_sys) cnt = -1;
            else if (hs) begin
                cnt = lat;
                pa = a;
            end else if (cnt > 0) cnt--;
            if (cnt == 0) begin
                i_imem_rsp_vld = 1;
                i_imem_rsp_instr = mem(pa);
                cnt = -1;
            end
        end
    end

    initial begin
        logic pv;
        logic [31:0] ppc, pin;
        logic [63:0] e;
        pv = 0;
        ppc = 0;
        pin = 0;
        forever begin
            @(negedge clk_sys);
            if (!rst_sys && o_imem_req_vld && i_imem_req_rdy) begin
                if (exp_addr.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL req_addr: unexpected request to %h", o_imem_addr);
                end else cmp("req_addr", o_imem_addr, exp_addr.pop_front());
            end
            if (o_instr_vld && (!pv || o_pc_d !== ppc || o_instr_d !== pin)) begin
                if (exp_load.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL ifid_load: unexpected load pc %h instr %h", o_pc_d, o_instr_d);
                end else begin
                    e = exp_load.pop_front();
                    cmp("ifid_pc", o_pc_d, e[63:32]);
                    cmp("ifid_instr", o_instr_d, e[31:0]);
                end
            end
            pv = o_instr_vld;
            ppc = o_pc_d;
            pin = o_instr_d;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_sys = 1;
        i_imem_req_rdy = 1;
        i_redirect = 0;
        i_redirect_pc = 0;
        i_if2id_stall = 0;
        i_if2id_flush = 0;
        push(32'h0, 1); push(32'h4, 1); push(32'h8, 1); push(32'hC, 1);
        push(32'h10, 1); push(32'h14, 1);
        push(32'h18, 0); push(32'h100, 1);
        push(32'h104, 0); push(32'h200, 1);
        push(32'h204, 1);
        push(32'h208, 0); push(32'hFFFF_FFFC, 1); push(32'h0, 1);
        repeat (2) @(negedge clk_sys);
        cmp("rst_req_vld", o_imem_req_vld, 0);
        cmp("rst_instr_vld", o_instr_vld, 0);
        cmp("rst_instr_d", o_instr_d, NOP);
        cmp("rst_pc_d", o_pc_d, 0);
        step();
        rst_sys = 0;
        @(negedge clk_sys);
        cmp("first_req_vld", o_imem_req_vld, 1);
        cmp("first_req_addr", o_imem_addr, 0);
        // back-pressure: request to 0x10 must hold steady for three cycles
        wait_req(32'hC);
        step();
        i_imem_req_rdy = 0;
        wait_req(32'h10);
        for (int i = 0; i < 3; i++) begin
            cmp("bp_req_vld", o_imem_req_vld, 1);
            cmp("bp_addr", o_imem_addr, 32'h10);
            cmp("bp_pc_d", o_pc_d, 32'hC);
            if (i < 2) @(negedge clk_sys);
        end
        step();
        i_imem_req_rdy = 1;
        lat = 1;
        // stall while waiting: DEADBEEF parks in the hold buffer
        wait_req(32'h14);
        step();
        i_if2id_stall = 1;
        repeat (4) @(negedge clk_sys);
        cmp("hold_req_vld", o_imem_req_vld, 0);
        cmp("hold_pc_d", o_pc_d, 32'h10);
        cmp("hold_instr_d", o_instr_d, mem(32'h10));
        step();
        i_if2id_stall = 0;
        lat = 2;
        // redirect in WAIT before the response: stale response is killed
        wait_req(32'h18);
        step();
        i_redirect = 1;
        i_redirect_pc = 32'h103;
        step();
        i_redirect = 0;
        lat = 0;
        @(negedge clk_sys);
        cmp("kill_instr_vld", o_instr_vld, 0);
        cmp("kill_instr_d", o_instr_d, NOP);
        cmp("kill_req_vld", o_imem_req_vld, 0);
        // flush + redirect together while stalled in HOLD
        wait_req(32'h104);
        step();
        i_if2id_stall = 1;
        step();
        i_redirect = 1;
        i_if2id_flush = 1;
        i_redirect_pc = 32'h200;
        step();
        i_redirect = 0;
        i_if2id_flush = 0;
        @(negedge clk_sys);
        cmp("fr_instr_vld", o_instr_vld, 0);
        cmp("fr_instr_d", o_instr_d, NOP);
        cmp("fr_req_vld", o_imem_req_vld, 1);
        cmp("fr_addr", o_imem_addr, 32'h200);
        step();
        i_if2id_stall = 0;
        // flush alone: the arriving instruction is kept and loads afterwards
        wait_req(32'h204);
        step();
        i_if2id_flush = 1;
        step();
        i_if2id_flush = 0;
        @(negedge clk_sys);
        cmp("fl_instr_vld", o_instr_vld, 0);
        cmp("fl_pc_d", o_pc_d, 32'h200);
        // redirect with a response in the same cycle, to the top of the address space
        wait_req(32'h208);
        step();
        i_redirect = 1;
        i_redirect_pc = 32'hFFFF_FFFF;
        step();
        i_redirect = 0;
        wait_req(32'h0);
        step();
        i_imem_req_rdy = 0;
        repeat (4) @(negedge clk_sys);
        cmp("addr_queue_empty", exp_addr.size(), 0);
        cmp("load_queue_empty", exp_load.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: generates the PC, issues single-outstanding requests to instruction memory over a valid/ready handshake, and loads the IF/ID pipeline register that drives the decode stage's `i_pc`/`i_instr`. It sits between instruction memory and the decode unit. It obeys hazard-control stall/flush and EXU redirects, and holds one prefetched instruction while decode is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `INSTR_WIDTH`, 32, instruction width
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)

- `clk_sys`  in  1  system clock
- `rst_sys`  in  1  synchronous active-high reset
- `o_imem_req_vld`  out  1  fetch request valid
- `i_imem_req_rdy`  in  1  memory accepts request
- `o_imem_addr`  out  32  fetch address, word aligned
- `i_imem_rsp_vld`  in  1  response valid; memory never back-pressured
- `i_imem_rsp_instr`  in  INSTR_WIDTH  fetched instruction
- `i_redirect`  in  1  EXU taken branch/jump
- `i_redirect_pc`  in  32  redirect target
- `i_if2id_stall`  in  1  hold IF/ID register
- `i_if2id_flush`  in  1  load bubble into IF/ID
- `o_pc_d`  out  32  IF/ID PC to decode
- `o_instr_d`  out  INSTR_WIDTH  IF/ID instruction to decode
- `o_instr_vld`  out  1  IF/ID content is a real instruction

## Operation
- FSM states: REQ, WAIT, HOLD, KILL. Reset state is REQ.
- REQ: `o_imem_req_vld`=1 and `o_imem_addr`=pc. On `req_vld & req_rdy`, go to WAIT. REQ issues even while stalled (one-deep prefetch).
- WAIT: on `rsp_vld` with stall=0, load IF/ID with {pc, instr, vld=1}, set pc+=4, go to REQ. On `rsp_vld` with stall=1, capture instr and pc in the hold buffer and go to HOLD.
- HOLD: no request is issued. When stall drops, load IF/ID from the buffer, set pc+=4, go to REQ.
- KILL: entered on a redirect while in WAIT with no response that cycle. The next `rsp_vld` is discarded, then go to REQ. pc already holds the target.
- Redirect in any state: pc <= {i_redirect_pc[31:2],2'b00}, hold buffer invalidated, IF/ID loaded with {NOP_INSTR, vld=0}. Next state:
  - REQ, if the request handshake does not complete this cycle.
  - KILL, if the request handshake completes this cycle, or if in WAIT without a response.
  - REQ, if in WAIT with a response in the same cycle; that response is dropped.
  - REQ, if in HOLD.
- Flush without redirect: IF/ID <= {NOP_INSTR, pc unchanged, vld=0}. A buffered or arriving instruction is not dropped and loads on a later cycle.
- IF/ID priority: rst_sys > redirect > flush > stall > new load > hold value.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values: `o_imem_req_vld`=0 while rst_sys=1; pc=RESET_PC; `o_pc_d`=0; `o_instr_d`=NOP_INSTR; `o_instr_vld`=0; state=REQ; hold buffer invalid.
- First request is asserted in the first cycle after reset deasserts.
- Latency: a response in cycle N appears on `o_instr_d` in cycle N+1.
- Peak throughput: one instruction per 2 cycles with zero-wait memory.
- `o_imem_addr` and `o_imem_req_vld` are stable while `req_vld & !req_rdy`, unless a redirect occurs. A redirect retargets the pending request in the same cycle.
- Reset mid-fetch: the outstanding response after reset is not tracked. Memory must drop in-flight responses on rst_sys.

## Structure
- Shared package holds `NOP_INSTR`, the FSM state encoding (2-bit), and `INSTR_WIDTH`.
- The IF/ID register uses the existing `DFF_RST_EN_CLR` sub-module: en = load condition, clr = redirect|flush. clr loads NOP via an explicit mux for `o_instr_d`.
- PC and hold buffer are local registers.

## Test plan
- Reset then zero-wait memory returning 32'h0000_0093 at addr 0 → `o_imem_addr` sequence 0,4,8; `o_instr_d`=32'h0000_0093, `o_pc_d`=0, vld=1 one cycle after the response.
- `req_rdy`=0 for 3 cycles → addr held at 0x10, req_vld held high, no IF/ID change.
- Stall asserted in WAIT, response 32'hDEAD_BEEF arrives → IF/ID unchanged; releasing stall loads DEADBEEF with the correct PC; next request is at pc+4.
- Redirect to 0x103 in WAIT, then a stale response → stale response dropped; next request addr 0x100; `o_instr_vld`=0 for the redirect cycle.
- Flush and redirect in the same cycle while stalled → IF/ID = NOP, vld=0; pc = target.
- Redirect to 0xFFFF_FFFC → fetches at 0xFFFF_FFFC then 0x0000_0000.
